// File: rtl/controller_fsm.sv
// rtl/controller_fsm.sv - multi-cycle instruction controller: fetch/decode/execute FSM driving ROM, data memory and register-file datapath
module controller_fsm (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  I_addr,
  output logic        I_rd,
  input  logic [15:0] I_data,
  output logic [7:0]  D_addr,
  output logic        D_rd,
  output logic        D_wr,
  output logic [3:0]  Rf_writeAddress,
  output logic        Rf_we,
  output logic [3:0]  Rf_readAddress1,
  output logic [3:0]  Rf_readAddress2,
  output logic        alu_s1,
  output logic        alu_s0,
  output logic        Rf_s1,
  output logic        Rf_s0,
  output logic [7:0]  Rf_W_data,
  input  logic        isEqual,
  output logic        halted
);

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_MOVI  = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JEQ   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ALU    = 4'd5,
    S_MOVI   = 4'd6,
    S_JEQ    = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  pc;
  logic [7:0]  pc_next;
  logic [15:0] ir;
  logic [15:0] ir_next;

  logic [3:0]  op;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic [7:0]  d8;
  logic [7:0]  jeq_target;

  assign op = ir[15:12];
  assign ra = ir[11:8];
  assign rb = ir[7:4];
  assign rc = ir[3:0];
  assign d8 = ir[7:0];

  // Branch offset is signed 4-bit, applied to the PC already advanced by FETCH
  assign jeq_target = pc + {{4{rc[3]}}, rc};

  // State, program counter and instruction register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_INIT;
      pc    <= 8'd0;
      ir    <= 16'd0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

  // Next-state and Moore outputs; everything is forced low while reset is held
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    ir_next         = ir;
    I_addr          = 8'd0;
    I_rd            = 1'b0;
    D_addr          = 8'd0;
    D_rd            = 1'b0;
    D_wr            = 1'b0;
    Rf_writeAddress = 4'd0;
    Rf_we           = 1'b0;
    Rf_readAddress1 = 4'd0;
    Rf_readAddress2 = 4'd0;
    alu_s1          = 1'b0;
    alu_s0          = 1'b0;
    Rf_s1           = 1'b0;
    Rf_s0           = 1'b0;
    Rf_W_data       = 8'd0;
    halted          = 1'b0;

    if (rst_n) begin
      case (state)
        S_INIT: begin
          state_next = S_FETCH;
        end

        S_FETCH: begin
          I_rd       = 1'b1;
          I_addr     = pc;
          ir_next    = I_data;
          pc_next    = pc + 8'd1;
          state_next = S_DECODE;
        end

        S_DECODE: begin
          case (op)
            OP_LOAD:                state_next = S_LOAD;
            OP_STORE:               state_next = S_STORE;
            OP_ADD, OP_SUB, OP_AND: state_next = S_ALU;
            OP_MOVI:                state_next = S_MOVI;
            OP_JEQ:                 state_next = S_JEQ;
            OP_HALT:                state_next = S_HALT;
            default:                state_next = S_FETCH;
          endcase
        end

        S_LOAD: begin
          D_addr          = d8;
          D_rd            = 1'b1;
          Rf_s0           = 1'b1;
          Rf_writeAddress = ra;
          Rf_we           = 1'b1;
          state_next      = S_FETCH;
        end

        S_STORE: begin
          Rf_readAddress1 = ra;
          D_addr          = d8;
          D_wr            = 1'b1;
          state_next      = S_FETCH;
        end

        S_ALU: begin
          Rf_readAddress1 = rb;
          Rf_readAddress2 = rc;
          case (op)
            OP_SUB:  alu_s0 = 1'b1;
            OP_AND:  alu_s1 = 1'b1;
            default: alu_s0 = 1'b0;
          endcase
          Rf_writeAddress = ra;
          Rf_we           = 1'b1;
          state_next      = S_FETCH;
        end

        S_MOVI: begin
          Rf_W_data       = d8;
          Rf_s1           = 1'b1;
          Rf_writeAddress = ra;
          Rf_we           = 1'b1;
          state_next      = S_FETCH;
        end

        S_JEQ: begin
          Rf_readAddress1 = ra;
          Rf_readAddress2 = rb;
          if (isEqual) begin
            pc_next = jeq_target;
          end
          state_next = S_FETCH;
        end

        S_HALT: begin
          halted     = 1'b1;
          state_next = S_HALT;
        end

        default: begin
          state_next = S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controller_fsm.sv
// tb/tb_controller_fsm.sv - randomized scoreboard bench for controller_fsm against an instruction-level model
module tb_controller_fsm;

  logic        clk;
  logic        rst_n;
  logic [7:0]  I_addr;
  logic        I_rd;
  logic [15:0] I_data;
  logic [7:0]  D_addr;
  logic        D_rd;
  logic        D_wr;
  logic [3:0]  Rf_writeAddress;
  logic        Rf_we;
  logic [3:0]  Rf_readAddress1;
  logic [3:0]  Rf_readAddress2;
  logic        alu_s1;
  logic        alu_s0;
  logic        Rf_s1;
  logic        Rf_s0;
  logic [7:0]  Rf_W_data;
  logic        isEqual;
  logic        halted;

  typedef struct packed {
    logic [7:0] i_addr;
    logic       i_rd;
    logic [7:0] d_addr;
    logic       d_rd;
    logic       d_wr;
    logic [3:0] wa;
    logic       we;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic       a1;
    logic       a0;
    logic       s1;
    logic       s0;
    logic [7:0] w_data;
    logic       hlt;
  } outs_t;

  typedef struct {
    int    gap;
    outs_t o;
  } ev_t;

  logic [15:0] rom [256];
  logic [255:0] eq_tab;
  ev_t  q[$];
  outs_t act;
  logic mon_en;
  int   checks;
  int   errors;
  int   since;
  int   ev_idx;
  ev_t  cur;

  controller_fsm dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .I_addr          (I_addr),
    .I_rd            (I_rd),
    .I_data          (I_data),
    .D_addr          (D_addr),
    .D_rd            (D_rd),
    .D_wr            (D_wr),
    .Rf_writeAddress (Rf_writeAddress),
    .Rf_we           (Rf_we),
    .Rf_readAddress1 (Rf_readAddress1),
    .Rf_readAddress2 (Rf_readAddress2),
    .alu_s1          (alu_s1),
    .alu_s0          (alu_s0),
    .Rf_s1           (Rf_s1),
    .Rf_s0           (Rf_s0),
    .Rf_W_data       (Rf_W_data),
    .isEqual         (isEqual),
    .halted          (halted)
  );

  assign act = {I_addr, I_rd, D_addr, D_rd, D_wr, Rf_writeAddress, Rf_we,
                Rf_readAddress1, Rf_readAddress2, alu_s1, alu_s0, Rf_s1, Rf_s0,
                Rf_W_data, halted};

  // ROM answers only while fetching; comparator is a lookup on the read addresses
  assign I_data  = I_rd ? rom[I_addr] : 16'hdead;
  assign isEqual = eq_tab[{Rf_readAddress1, Rf_readAddress2}];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input int gap, input outs_t o);
    ev_t e;
    e.gap = gap;
    e.o   = o;
    q.push_back(e);
  endtask

  // Interpret n instructions from PC=0 and queue every visible cycle with its distance from the previous one
  task automatic model_run(input int n);
    logic [7:0]  pc;
    logic [15:0] ir;
    outs_t       o;
    int          gap;
    pc  = 8'd0;
    gap = 2;
    for (int k = 0; k < n; k++) begin
      ir = rom[pc];
      o = '0;
      o.i_addr = pc;
      o.i_rd   = 1'b1;
      push(gap, o);
      pc = pc + 8'd1;
      o = '0;
      case (ir[15:12])
        4'h0: begin
          o.d_addr = ir[7:0]; o.d_rd = 1'b1; o.s0 = 1'b1; o.wa = ir[11:8]; o.we = 1'b1;
          push(2, o); gap = 1;
        end
        4'h1: begin
          o.ra1 = ir[11:8]; o.d_addr = ir[7:0]; o.d_wr = 1'b1;
          push(2, o); gap = 1;
        end
        4'h2, 4'h4, 4'h6: begin
          o.ra1 = ir[7:4]; o.ra2 = ir[3:0]; o.wa = ir[11:8]; o.we = 1'b1;
          o.a0 = (ir[15:12] == 4'h4);
          o.a1 = (ir[15:12] == 4'h6);
          push(2, o); gap = 1;
        end
        4'h3: begin
          o.w_data = ir[7:0]; o.s1 = 1'b1; o.wa = ir[11:8]; o.we = 1'b1;
          push(2, o); gap = 1;
        end
        4'h5: begin
          if (eq_tab[ir[11:4]]) pc = pc + {{4{ir[3]}}, ir[3:0]};
          gap = 3;
        end
        4'hF: begin
          o.hlt = 1'b1;
          push(2, o);
          for (int h = 0; h < 10; h++) push(1, o);
          return;
        end
        default: gap = 2;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("outputs_in_reset", 64'(act), 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic start(input int n);
    model_run(n);
    mon_en = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d events outstanding, required 0", name, q.size());
      q.delete();
    end
    mon_en = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h7000;
    eq_tab = '0;
  endtask

  // Monitor: every cycle with a strobe or halted pops one expected event and compares it
  initial begin
    since  = 0;
    ev_idx = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) since = 0;
      else since++;
      if (mon_en && rst_n) begin
        checks++;
        if (I_rd && (Rf_we || D_wr || D_rd)) begin
          errors++;
          $display("FAIL strobe_overlap: I_rd=%b Rf_we=%b D_wr=%b D_rd=%b, required no overlap",
                   I_rd, Rf_we, D_wr, D_rd);
        end
        if (I_rd || D_rd || D_wr || Rf_we || halted) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %h, required no activity", act);
          end else begin
            cur = q.pop_front();
            if (act !== cur.o || since != cur.gap) begin
              errors++;
              $display("FAIL event_%0d: got %h after %0d cycles, required %h after %0d cycles",
                       ev_idx, act, since, cur.o, cur.gap);
            end
          end
          ev_idx++;
          since = 0;
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    clear_rom();

    // Directed program: MOVI, ADD, LOAD, STORE, NOP, JEQ back to 4 while equal
    rom[0] = 16'h3A5C;
    rom[1] = 16'h2312;
    rom[2] = 16'h0740;
    rom[3] = 16'h1740;
    rom[4] = 16'h7000;
    rom[5] = 16'h512E;
    eq_tab[8'h12] = 1'b1;
    do_reset();
    start(12);
    drain("jeq_taken");

    // Same program with JEQ not taken, falling into HALT
    eq_tab = '0;
    rom[6] = 16'hF000;
    do_reset();
    start(7);
    drain("jeq_not_taken_halt");

    // PC wrap: backward jump from 1 to 249, then NOPs through 255 -> 0
    clear_rom();
    rom[0] = 16'h5008;
    eq_tab[8'h00] = 1'b1;
    do_reset();
    start(20);
    drain("pc_wrap");

    // Random programs without HALT
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) begin
        int sel;
        sel = $urandom_range(0, 9);
        rom[i][11:0] = 12'($urandom);
        if (sel <= 6) rom[i][15:12] = 4'(sel);
        else          rom[i][15:12] = 4'(7 + $urandom_range(0, 7));
      end
      for (int i = 0; i < 256; i++) eq_tab[i] = 1'($urandom_range(0, 1));
      do_reset();
      start(40);
      drain("random");
    end

    // Reset pulse while in the ALU state of ADD R3,R1,R2
    clear_rom();
    rom[0] = 16'h3A5C;
    rom[1] = 16'h2312;
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    check("alu_we_before_reset", 64'(Rf_we), 64'd1);
    rst_n = 1'b0;
    #1;
    check("outputs_during_alu_reset", 64'(act), 64'd0);
    @(posedge clk);
    #1;
    check("outputs_after_alu_reset_edge", 64'(act), 64'd0);
    rst_n = 1'b1;
    start(2);
    drain("restart_after_alu_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
